// File: rtl/updown_counter_if.sv
// Control and status bundle for updown_counter: count/load controls in, count and wrap out.
interface updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] no;
    logic             wrap;

    modport master (output en, up_dn, load, load_val, input no, wrap);
    modport slave  (input en, up_dn, load, load_val, output no, wrap);
endinterface

// File: rtl/updown_counter.sv
// Parametrised modulo-MODULO up/down counter with clamped parallel load and registered wrap pulse.
// Define UDC_SATURATE_EN to saturate at the range ends instead of wrapping (wrap then flags a blocked step).
module updown_counter #(
    parameter int     WIDTH  = 4,
    parameter longint MODULO = 16
) (
    input logic             clk,
    input logic             rst,
    updown_counter_if.slave bus
);
    // MODULO may equal 2^WIDTH, so the top value is derived in 64-bit before truncation.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'sd1);

    logic [WIDTH-1:0] countQ;
    logic             wrapQ;
    logic [WIDTH-1:0] countNext;
    logic             wrapNext;

    always_comb begin
        countNext = countQ;
        wrapNext  = 1'b0;
        if (bus.load) begin
            countNext = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (countQ == MAX_VAL) begin
                    wrapNext = 1'b1;
`ifdef UDC_SATURATE_EN
                    countNext = MAX_VAL;
`else
                    countNext = '0;
`endif
                end else begin
                    countNext = countQ + WIDTH'(1);
                end
            end else begin
                if (countQ == '0) begin
                    wrapNext = 1'b1;
`ifdef UDC_SATURATE_EN
                    countNext = '0;
`else
                    countNext = MAX_VAL;
`endif
                end else begin
                    countNext = countQ - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            countQ <= '0;
            wrapQ  <= 1'b0;
        end else begin
            countQ <= countNext;
            wrapQ  <= wrapNext;
        end
    end

    assign bus.no   = countQ;
    assign bus.wrap = wrapQ;
endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter: default, MODULO=10 and WIDTH=1/MODULO=2 instances.
module tb_updown_counter;
`ifdef UDC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    updown_counter_if #(.WIDTH(4)) ifD ();
    updown_counter_if #(.WIDTH(4)) ifM ();
    updown_counter_if #(.WIDTH(1)) ifW ();

    updown_counter #(.WIDTH(4), .MODULO(16)) dutD (.clk(clk), .rst(rst), .bus(ifD.slave));
    updown_counter #(.WIDTH(4), .MODULO(10)) dutM (.clk(clk), .rst(rst), .bus(ifM.slave));
    updown_counter #(.WIDTH(1), .MODULO(2))  dutW (.clk(clk), .rst(rst), .bus(ifW.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one instance (sel 0/1/2), idles the others, then waits one edge and settles.
    task automatic applyStimulus(input int sel, input logic rstV, input logic enV,
                                 input logic upV, input logic loadV, input logic [3:0] valV);
        rst          = rstV;
        ifD.en       = (sel == 0) ? enV : 1'b0;
        ifD.up_dn    = upV;
        ifD.load     = (sel == 0) ? loadV : 1'b0;
        ifD.load_val = valV;
        ifM.en       = (sel == 1) ? enV : 1'b0;
        ifM.up_dn    = upV;
        ifM.load     = (sel == 1) ? loadV : 1'b0;
        ifM.load_val = valV;
        ifW.en       = (sel == 2) ? enV : 1'b0;
        ifW.up_dn    = upV;
        ifW.load     = (sel == 2) ? loadV : 1'b0;
        ifW.load_val = valV[0];
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);

        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("reset_no",     ifD.no,   0);
        checkOutput("reset_wrap",   ifD.wrap, 0);
        checkOutput("reset_no_w1",  ifW.no,   0);

        // Up-count 20 cycles from 0.
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
            checkOutput($sformatf("up_no_%0d", i),   ifD.no,
                        SAT ? ((i > 15) ? 15 : i) : (i % 16));
            checkOutput($sformatf("up_wrap_%0d", i), ifD.wrap,
                        SAT ? ((i >= 16) ? 1 : 0) : ((i == 16) ? 1 : 0));
        end

        // Down-count from reset.
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("dn_first_no",   ifD.no,   SAT ? 0 : 15);
        checkOutput("dn_first_wrap", ifD.wrap, 1);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("dn_second_no",   ifD.no,   SAT ? 0 : 14);
        checkOutput("dn_second_wrap", ifD.wrap, SAT ? 1 : 0);

        // Direction toggle at 5.
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        checkOutput("tog_load5", ifD.no, 5);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("tog_dn4", ifD.no, 4);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("tog_up5", ifD.no, 5);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("tog_up6", ifD.no, 6);

        // Down from 1 to 0 and beyond.
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("dn1_no",   ifD.no,   0);
        checkOutput("dn1_wrap", ifD.wrap, 0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("dn0_no",   ifD.no,   SAT ? 0 : 15);
        checkOutput("dn0_wrap", ifD.wrap, 1);

        // Hold at 7.
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
        checkOutput("hold_load7", ifD.no, 7);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
            checkOutput($sformatf("hold_no_%0d", i),   ifD.no,   7);
            checkOutput($sformatf("hold_wrap_%0d", i), ifD.wrap, 0);
        end

        // Reset beats load and enable; release resumes from 0.
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
        checkOutput("rstprio_no",   ifD.no,   0);
        checkOutput("rstprio_wrap", ifD.wrap, 0);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("rstrel_no", ifD.no, 1);

        // MODULO = 10.
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8);
        checkOutput("m10_load8", ifM.no, 8);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("m10_up9",      ifM.no,   9);
        checkOutput("m10_up9_wrap", ifM.wrap, 0);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("m10_wrap_no",  ifM.no,   SAT ? 9 : 0);
        checkOutput("m10_wrap",     ifM.wrap, 1);
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd12);
        checkOutput("m10_clamp12",  ifM.no,   9);
        checkOutput("m10_clampw",   ifM.wrap, 0);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
        checkOutput("m10_loadprio", ifM.no,   3);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("m10_dn0_no",   ifM.no,   SAT ? 0 : 9);
        checkOutput("m10_dn0_wrap", ifM.wrap, 1);

        // WIDTH = 1, MODULO = 2, from 0.
        applyStimulus(2, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        checkOutput("w1_load0", ifW.no, 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(2, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
            checkOutput($sformatf("w1_no_%0d", i),   ifW.no,   SAT ? 1 : (i % 2));
            checkOutput($sformatf("w1_wrap_%0d", i), ifW.wrap,
                        SAT ? ((i >= 2) ? 1 : 0) : ((i % 2 == 0) ? 1 : 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
